// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: shift-add significand product (one bit per cycle), RNE rounding,
// flush-to-zero for denormals, saturation to infinity, valid/ready handshakes on both sides.
module fp_mul_seq #(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    localparam int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         zero
);
    localparam int N  = MAN_W + 1;
    localparam int CW = $clog2(MAN_W + 2);
    localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'(2**(EXP_W-1) - 1);
    localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'(2**EXP_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
    state_t state, state_nxt;

    logic             sign_q, spec_z_q, spec_i_q;
    logic [EXP_W-1:0] ea_q, eb_q;
    logic [N-1:0]     mc;
    logic [2*N-1:0]   prod;
    logic [CW-1:0]    cnt;

    logic accept;
    assign accept = in_valid && in_ready;

    // One shift-add step: add the multiplicand to the upper half when the current multiplier bit is set.
    function automatic logic [2*N-1:0] step(input logic [2*N-1:0] p, input logic [N-1:0] m);
        logic [N:0] s;
        s = {1'b0, p[2*N-1:N]} + (p[0] ? {1'b0, m} : {(N+1){1'b0}});
        return {s, p[N-1:1]};
    endfunction

    logic [EXP_W-1:0] ea_in, eb_in;
    logic             z_in, i_in;
    assign ea_in = a[W-2:MAN_W];
    assign eb_in = b[W-2:MAN_W];
    assign z_in  = (ea_in == '0) || (eb_in == '0);
    assign i_in  = (ea_in == '1) || (eb_in == '1);

    // Normalisation and rounding of the finished product.
    logic signed [EXP_W+1:0] e0, e1, e2;
    logic [2*N-2:0]          sh;
    logic                    guard, sticky, rnd;
    logic [MAN_W:0]          fr;
    logic [W-1:0]            n_res;
    logic                    n_ovf, n_unf;

    always_comb begin
        e0     = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS;
        sh     = prod[2*N-1] ? prod[2*N-2:0] : {prod[2*N-3:0], 1'b0};
        e1     = prod[2*N-1] ? e0 + (EXP_W+2)'(1) : e0;
        guard  = sh[N-1];
        sticky = |sh[N-2:0];
        rnd    = guard && (sticky || sh[N]);
        fr     = {1'b0, sh[2*N-2:N]} + {{MAN_W{1'b0}}, rnd};
        e2     = fr[MAN_W] ? e1 + (EXP_W+2)'(1) : e1;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        n_res  = {sign_q, e2[EXP_W-1:0], fr[MAN_W-1:0]};
        if (e2 >= EMAX) begin
            n_ovf = 1'b1;
            n_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (e2 <= 0) begin
            n_unf = 1'b1;
            n_res = {sign_q, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = MUL;
            MUL:  if (spec_z_q || spec_i_q)   state_nxt = DONE;
                  else if (cnt == CW'(N - 1)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // The accept edge already performs the first iteration; MUL performs the remaining MAN_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q    <= 1'b0;
            spec_z_q  <= 1'b0;
            spec_i_q  <= 1'b0;
            ea_q      <= '0;
            eb_q      <= '0;
            mc        <= '0;
            prod      <= '0;
            cnt       <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sign_q   <= a[W-1] ^ b[W-1];
                    spec_z_q <= z_in;
                    spec_i_q <= i_in && !z_in;
                    ea_q     <= ea_in;
                    eb_q     <= eb_in;
                    mc       <= {1'b1, a[MAN_W-1:0]};
                    prod     <= step({{N{1'b0}}, 1'b1, b[MAN_W-1:0]}, {1'b1, a[MAN_W-1:0]});
                    cnt      <= CW'(1);
                end
                MUL: begin
                    if (spec_z_q) begin
                        result <= {sign_q, {(W-1){1'b0}}};
                        zero   <= 1'b1;
                    end else if (spec_i_q) begin
                        result   <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        overflow <= 1'b1;
                    end else begin
                        prod <= step(prod, mc);
                        cnt  <= cnt + CW'(1);
                    end
                end
                NORM: begin
                    result    <= n_res;
                    overflow  <= n_ovf;
                    underflow <= n_unf;
                    zero      <= 1'b0;
                end
                DONE: if (out_ready) begin
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                    zero      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq with hand-computed single-precision results.
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow, underflow, zero;

    int n_cmp = 0;
    int n_bad = 0;

    fp_mul_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_out(input string tag, input logic [31:0] er,
                             input logic eo, input logic eu, input logic ez);
        chk({tag, " result"}, result, er);
        chk({tag, " flags"}, {29'd0, overflow, underflow, zero}, {29'd0, eo, eu, ez});
        chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
        chk({tag, " flags cleared"}, {29'd0, overflow, underflow, zero}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] er, input logic eo, input logic eu, input logic ez,
                       input int lat);
        issue(tag, va, vb);
        wait_out(tag, lat);
        check_out(tag, er, eo, eu, ez);
        release_out(tag);
    endtask

    initial begin
        #12;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", {29'd0, overflow, underflow, zero}, 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run("basic",   32'h3F700000, 32'h3DB00000, 32'h3DA50000, 1'b0, 1'b0, 1'b0, 24);
        run("neg",     32'h40000000, 32'hBFC00000, 32'hC0400000, 1'b0, 1'b0, 1'b0, 24);
        run("rndup",   32'h3FC00001, 32'h3FC00000, 32'h40100001, 1'b0, 1'b0, 1'b0, 24);
        run("ovf",     32'h7F500000, 32'hBFD00000, 32'hFF800000, 1'b1, 1'b0, 1'b0, 24);
        run("unf",     32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 24);
        run("denorm",  32'h00500000, 32'hC0D00000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1);
        run("zeroinf", 32'h00000000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1);
        run("inf",     32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1);

        // Hold the result under backpressure while a stray operand pulse arrives.
        issue("stall", 32'h40000000, 32'h40400000);
        wait_out("stall", 24);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 32'h3F800000;
                b = 32'h3F800000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("stall out_valid", 32'(out_valid), 32'd1);
            check_out("stall", 32'h40C00000, 1'b0, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        release_out("stall");
        repeat (3) @(posedge clk);
        #1;
        chk("stray op ignored", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of the multiply.
        issue("rst", 32'h3F700000, 32'h3DB00000);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst result", result, 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_rst", 32'h40000000, 32'hBFC00000, 32'hC0400000, 1'b0, 1'b0, 1'b0, 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
